// File: rtl/lab1_imul_dot_prod_client_if.sv
// Handshake bundle for lab1_imul_dot_prod_client.
//   in_*       : operand-pair stream {last[64], a[63:32], b[31:0]}
//   mul_req_*  : multiply request to the multiplier {a, b}
//   mul_resp_* : product returned by the multiplier {result}
//   out_*      : dot-product result {count[47:32], sum[31:0]}
// master: the dot-product client. slave: the surrounding source/multiplier/sink.
interface lab1_imul_dot_prod_client_if;
    logic        in_val;
    logic        in_rdy;
    logic [64:0] in_msg;
    logic        mul_req_val;
    logic        mul_req_rdy;
    logic [63:0] mul_req_msg;
    logic        mul_resp_val;
    logic        mul_resp_rdy;
    logic [31:0] mul_resp_msg;
    logic        out_val;
    logic        out_rdy;
    logic [47:0] out_msg;

    modport master (
        input  in_val, in_msg, mul_req_rdy, mul_resp_val, mul_resp_msg, out_rdy,
        output in_rdy, mul_req_val, mul_req_msg, mul_resp_rdy, out_val, out_msg
    );

    modport slave (
        output in_val, in_msg, mul_req_rdy, mul_resp_val, mul_resp_msg, out_rdy,
        input  in_rdy, mul_req_val, mul_req_msg, mul_resp_rdy, out_val, out_msg
    );
endinterface

// File: rtl/lab1_imul_dot_prod_client.sv
// Dot-product client for the lab1_imul val/rdy multiplier.
// Forwards each operand pair as a multiply request (combinational pass-through,
// at most MAX_OUTSTANDING unanswered requests), sums the returned products and
// emits {count, sum} once per vector terminated by the last flag.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : lab1_imul_dot_prod_client_if.master (in / mul_req / mul_resp / out)
// Parameter: MAX_OUTSTANDING (1..7), default 2.
// Build option: define LAB1_IMUL_DOT_PROD_SAT_EN for unsigned-saturating
// accumulation; otherwise the sum wraps modulo 2^32.
module lab1_imul_dot_prod_client #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input logic                          clk,
    input logic                          reset,
    lab1_imul_dot_prod_client_if.master  bus
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  outstanding_q, outstanding_d;
    logic [15:0] count_q, count_d;
    logic [31:0] acc_q, acc_d;
    logic        credit_ok;
    logic        in_go;
    logic        req_go;
    logic        resp_go;

    // Credit check uses the registered count, so a same-cycle response
    // never frees a slot for an extra issue.
    assign credit_ok = (outstanding_q < 3'(MAX_OUTSTANDING));
    assign in_go     = bus.in_val && bus.in_rdy;
    assign req_go    = bus.mul_req_val && bus.mul_req_rdy;
    assign resp_go   = bus.mul_resp_val && bus.mul_resp_rdy;

    always_comb begin
        outstanding_d = outstanding_q;
        case ({req_go, resp_go})
            2'b10:   outstanding_d = outstanding_q + 3'd1;
            2'b01:   outstanding_d = outstanding_q - 3'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

`ifdef LAB1_IMUL_DOT_PROD_SAT_EN
    logic [32:0] acc_sum;
    assign acc_sum = {1'b0, acc_q} + {1'b0, bus.mul_resp_msg};
`endif

    always_comb begin
        state_d          = state_q;
        bus.in_rdy       = 1'b0;
        bus.mul_req_val  = 1'b0;
        bus.mul_req_msg  = bus.in_msg[63:0];
        bus.mul_resp_rdy = (outstanding_q != 3'd0);
        bus.out_val      = 1'b0;
        bus.out_msg      = '0;
        count_d          = count_q;
        acc_d            = acc_q;

        if (resp_go) begin
`ifdef LAB1_IMUL_DOT_PROD_SAT_EN
            acc_d = acc_sum[32] ? '1 : acc_sum[31:0];
`else
            acc_d = acc_q + bus.mul_resp_msg;
`endif
        end

        case (state_q)
            ISSUE: begin
                // in go and request go are the same event: in_rdy mirrors
                // mul_req_rdy, mul_req_val mirrors in_val, both credit-gated.
                bus.in_rdy      = bus.mul_req_rdy && credit_ok && !reset;
                bus.mul_req_val = bus.in_val && credit_ok && !reset;
                if (in_go) begin
                    count_d = count_q + 16'd1;
                    if (bus.in_msg[64]) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding_d == 3'd0) state_d = DONE;
            end
            DONE: begin
                bus.out_val = 1'b1;
                bus.out_msg = {count_q, acc_q};
                if (bus.out_rdy) begin
                    count_d = '0;
                    acc_d   = '0;
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ISSUE;
            outstanding_q <= '0;
            count_q       <= '0;
            acc_q         <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            acc_q         <= acc_d;
        end
    end

endmodule

// File: tb/tb_lab1_imul_dot_prod_client.sv
module tb_lab1_imul_dot_prod_client;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    lab1_imul_dot_prod_client_if bus ();

    lab1_imul_dot_prod_client #(.MAX_OUTSTANDING(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: in-order, fixed latency (cycles), optional random stalls.
    int unsigned cyc;
    int unsigned lat;
    bit          stall_en;
    int          resp_count;
    logic [31:0] pq[$];
    int unsigned pt[$];

    initial begin
        cyc = 0;
        resp_count = 0;
        bus.mul_req_rdy  = 1'b0;
        bus.mul_resp_val = 1'b0;
        bus.mul_resp_msg = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                pq.delete();
                pt.delete();
            end else begin
                if (bus.mul_resp_val && bus.mul_resp_rdy) begin
                    void'(pq.pop_front());
                    void'(pt.pop_front());
                    resp_count++;
                end
                if (bus.mul_req_val && bus.mul_req_rdy) begin
                    pq.push_back(bus.mul_req_msg[63:32] * bus.mul_req_msg[31:0]);
                    pt.push_back(cyc);
                end
            end
            @(negedge clk);
            bus.mul_req_rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pq.size() != 0 && (cyc - pt[0] + 1 >= lat) &&
                (!stall_en || $urandom_range(0, 1) == 1)) begin
                bus.mul_resp_val = 1'b1;
                bus.mul_resp_msg = pq[0];
            end else begin
                bus.mul_resp_val = 1'b0;
                bus.mul_resp_msg = '0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b,
                             input logic last, output int waits);
        waits = 0;
        @(negedge clk);
        bus.in_val = 1'b1;
        bus.in_msg = {last, a, b};
        #1;
        while (!bus.in_rdy && waits < 300) begin
            @(negedge clk);
            #1;
            waits++;
        end
        n_cmp++;
        if (bus.in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL send_timeout: in_rdy=%b required 1", bus.in_rdy);
        end
        @(posedge clk);
        #1 bus.in_val = 1'b0;
    endtask

    task automatic get_result(input logic [15:0] ecount, input logic [31:0] esum,
                              input bit rand_rdy, input string name);
        int          cycles = 0;
        bit          got = 0;
        bit          stalled = 0;
        logic [47:0] held = '0;
        while (!got && cycles < 500) begin
            @(negedge clk);
            bus.out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (bus.out_val) begin
                n_cmp++;
                if (bus.in_rdy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_in_rdy_done: in_rdy=%b required 0", name, bus.in_rdy);
                end
                if (stalled) begin
                    n_cmp++;
                    if (bus.out_msg !== held) begin
                        n_fail++;
                        $display("FAIL %s_out_stable: out_msg=%h required %h", name, bus.out_msg, held);
                    end
                end
                if (bus.out_rdy) begin
                    got = 1;
                    n_cmp++;
                    if (bus.out_msg !== {ecount, esum}) begin
                        n_fail++;
                        $display("FAIL %s_result: out_msg=%h required %h", name, bus.out_msg, {ecount, esum});
                    end
                end else begin
                    stalled = 1;
                    held = bus.out_msg;
                end
            end
            cycles++;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: out_val=%b required 1", name, bus.out_val);
        end
        @(posedge clk);
        #1 bus.out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_val = 1'b1;
        bus.in_msg = {1'b0, 32'd5, 32'd6};
        bus.out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (bus.in_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_in_rdy: in_rdy=%b required 0", bus.in_rdy); end
        n_cmp++;
        if (bus.mul_req_val !== 1'b0) begin n_fail++; $display("FAIL rst_req_val: mul_req_val=%b required 0", bus.mul_req_val); end
        n_cmp++;
        if (bus.mul_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_resp_rdy: mul_resp_rdy=%b required 0", bus.mul_resp_rdy); end
        n_cmp++;
        if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL rst_out_val: out_val=%b required 0", bus.out_val); end
        n_cmp++;
        if (bus.out_msg !== 48'd0) begin n_fail++; $display("FAIL rst_out_msg: out_msg=%h required 0", bus.out_msg); end
        @(negedge clk);
        reset = 1'b0;
        bus.in_val = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_rdy: in_rdy=%b required 1", bus.in_rdy); end
        n_cmp++;
        if (bus.mul_req_val !== 1'b0) begin n_fail++; $display("FAIL post_rst_req_val: mul_req_val=%b required 0", bus.mul_req_val); end
    endtask

    task automatic test_basic();
        int w;
        lat = 1;
        send_pair(32'd2, 32'd3, 1'b0, w);
        n_cmp++;
        if (w !== 0) begin n_fail++; $display("FAIL basic_tput0: waits=%0d required 0", w); end
        send_pair(32'd4, 32'd5, 1'b0, w);
        n_cmp++;
        if (w !== 0) begin n_fail++; $display("FAIL basic_tput1: waits=%0d required 0", w); end
        send_pair(32'd6, 32'd7, 1'b1, w);
        n_cmp++;
        if (w !== 0) begin n_fail++; $display("FAIL basic_tput2: waits=%0d required 0", w); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL basic_drain: out_val=%b required 0", bus.out_val); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.out_val !== 1'b1) begin n_fail++; $display("FAIL basic_done_time: out_val=%b required 1", bus.out_val); end
        get_result(16'd3, 32'h44, 1'b0, "basic");
        repeat (4) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL basic_single: out_val=%b required 0", bus.out_val); end
        end
    endtask

    task automatic test_credit();
        int w;
        lat = 10;
        send_pair(32'd1, 32'd2, 1'b0, w);
        send_pair(32'd3, 32'd4, 1'b0, w);
        @(negedge clk);
        bus.in_val = 1'b1;
        bus.in_msg = {1'b0, 32'd5, 32'd6};
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++;
            if (bus.mul_req_val !== 1'b0 || bus.in_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL credit_hold: mul_req_val=%b in_rdy=%b required 0 0", bus.mul_req_val, bus.in_rdy);
            end
            @(negedge clk);
        end
        w = 0;
        #1;
        while (!bus.in_rdy && w < 300) begin
            @(negedge clk);
            #1;
            w++;
        end
        n_cmp++;
        if (bus.mul_req_val !== 1'b1 || resp_count < 1) begin
            n_fail++;
            $display("FAIL credit_release: mul_req_val=%b responses=%0d required 1 and >=1", bus.mul_req_val, resp_count);
        end
        @(posedge clk);
        #1 bus.in_val = 1'b0;
        send_pair(32'd7, 32'd8, 1'b1, w);
        get_result(16'd4, 32'd100, 1'b0, "credit");
        lat = 1;
    endtask

    task automatic test_wrap();
        int w;
        logic [31:0] esum;
`ifdef LAB1_IMUL_DOT_PROD_SAT_EN
        esum = 32'hFFFF_FFFF;
`else
        esum = 32'h0000_0001;
`endif
        lat = 1;
        send_pair(32'hFFFF_FFFF, 32'd1, 1'b0, w);
        send_pair(32'd2, 32'd1, 1'b1, w);
        get_result(16'd2, esum, 1'b0, "wrap");
    endtask

    task automatic test_reset_mid();
        int w;
        lat = 10;
        send_pair(32'd1, 32'd1, 1'b0, w);
        send_pair(32'd2, 32'd2, 1'b0, w);
        @(negedge clk);
        reset = 1'b1;
        bus.in_val = 1'b1;
        bus.in_msg = {1'b0, 32'd3, 32'd3};
        #1;
        n_cmp++;
        if (bus.in_rdy !== 1'b0 || bus.mul_req_val !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_force: in_rdy=%b mul_req_val=%b required 0 0", bus.in_rdy, bus.mul_req_val);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.in_val = 1'b0;
        #1;
        n_cmp++;
        if (bus.mul_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_resp_rdy: mul_resp_rdy=%b required 0", bus.mul_resp_rdy); end
        n_cmp++;
        if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_val: out_val=%b required 0", bus.out_val); end
        lat = 1;
        send_pair(32'd1, 32'd1, 1'b1, w);
        get_result(16'd1, 32'd1, 1'b0, "mid_rst");
    endtask

    task automatic test_back_to_back();
        int w;
        lat = 1;
        send_pair(32'd9, 32'd9, 1'b1, w);
        get_result(16'd1, 32'd81, 1'b0, "b2b_first");
        send_pair(32'd3, 32'd3, 1'b1, w);
        get_result(16'd1, 32'd9, 1'b0, "b2b_second");
    endtask

    task automatic test_backpressure();
        int w;
        int unsigned n;
        logic [31:0] a, b, esum;
        stall_en = 1'b1;
        for (int v = 0; v < 50; v++) begin
            lat = $urandom_range(1, 4);
            n = $urandom_range(1, 6);
            esum = '0;
            for (int unsigned i = 0; i < n; i++) begin
                a = $urandom_range(0, 4095);
                b = $urandom_range(0, 4095);
                esum = esum + a * b;
                send_pair(a, b, (i == n - 1), w);
            end
            get_result(16'(n), esum, 1'b1, "bp");
        end
        stall_en = 1'b0;
        lat = 1;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        lat = 1;
        stall_en = 1'b0;
        reset = 1'b1;
        bus.in_val = 1'b0;
        bus.in_msg = '0;
        bus.out_rdy = 1'b0;
        test_reset();
        test_basic();
        test_credit();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
